// File: rtl/arf_pkg.sv
// Shared types and constants for the ARF error-sweep sequencer.
package arf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GEN, S_SETTLE, S_CAPTURE, S_DONE} arf_state_e;

  // Right-shift Galois form of x^64+x^63+x^61+x^60+1
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam int DEF_ER_THRESH1  = 8;
  localparam int DEF_INPUT_WIDTH = 16;

  localparam int NUM_LANES   = 10;
  localparam int LANE_IN_1_0 = 0;
  localparam int LANE_IN_2_0 = 1;
  localparam int LANE_IN_3_0 = 2;
  localparam int LANE_IN_4_0 = 3;
  localparam int LANE_IN_5_0 = 4;
  localparam int LANE_IN_6_0 = 5;
  localparam int LANE_IN_7_0 = 6;
  localparam int LANE_IN_8_0 = 7;
  localparam int LANE_IN_13_1 = 8;
  localparam int LANE_IN_14_1 = 9;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction
endpackage

// File: rtl/arf_err_acc.sv
// Error metrics for one datapath output: error counts, signed error sum, max |error|.
module arf_err_acc #(
  parameter int DW         = 32,
  parameter int ER_THRESH1 = 8,
  parameter int CNT_W      = 32,
  parameter int SUM_W      = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    approx,
  input  logic [DW-1:0]    exact,
  output logic [CNT_W-1:0] er0_cnt,
  output logic [CNT_W-1:0] er1_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [DW:0]      abs_max
);
  logic [DW:0] err, mag;
  logic        hi_diff;

  // One extra bit keeps both the difference and its magnitude exact
  assign err     = {approx[DW-1], approx} - {exact[DW-1], exact};
  assign mag     = err[DW] ? (~err + (DW+1)'(1)) : err;
  assign hi_diff = approx[DW-1:ER_THRESH1] != exact[DW-1:ER_THRESH1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      er0_cnt <= '0;
      er1_cnt <= '0;
      err_sum <= '0;
      abs_max <= '0;
    end else if (clr) begin
      er0_cnt <= '0;
      er1_cnt <= '0;
      err_sum <= '0;
      abs_max <= '0;
    end else if (en) begin
      if (err != '0 && er0_cnt != '1) er0_cnt <= er0_cnt + CNT_W'(1);
      if (hi_diff && er1_cnt != '1)   er1_cnt <= er1_cnt + CNT_W'(1);
      err_sum <= err_sum + {{(SUM_W-DW-1){err[DW]}}, err};
      if (mag > abs_max) abs_max <= mag;
    end
  end
endmodule

// File: rtl/arf_err_sweep_ctrl.sv
// Error-sweep sequencer: drives LFSR vectors into both ARF datapaths, settles, captures, accumulates.
module arf_err_sweep_ctrl
  import arf_pkg::*;
#(
  parameter int DW          = 32,
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int ER_THRESH1  = DEF_ER_THRESH1,
  parameter int SETTLE      = 4,
  parameter int CNT_W       = 32,
  parameter int SUM_W       = 48
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_W-1:0]              num_samples,
  input  logic [63:0]                   seed,
  output logic [NUM_LANES-1:0][DW-1:0]  vec_data,
  output logic                          vec_valid,
  input  logic [DW-1:0]                 out_27_var,
  input  logic [DW-1:0]                 out_27_acc,
  input  logic [DW-1:0]                 out_28_var,
  input  logic [DW-1:0]                 out_28_acc,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              sample_cnt,
  output logic [CNT_W-1:0]              er0_cnt_27,
  output logic [CNT_W-1:0]              er0_cnt_28,
  output logic [CNT_W-1:0]              er1_cnt_27,
  output logic [CNT_W-1:0]              er1_cnt_28,
  output logic [SUM_W-1:0]              err_sum_27,
  output logic [SUM_W-1:0]              err_sum_28,
  output logic [DW:0]                   abs_max_27,
  output logic [DW:0]                   abs_max_28
);
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  arf_state_e       st;
  logic [3:0]       lane;
  logic [SCW-1:0]   scnt;
  logic [63:0]      lfsr, lfsr_nx;
  logic [CNT_W-1:0] n_lat;
  logic [DW-1:0]    lane_val;
  logic             done_q, clr, cap;

  assign lfsr_nx  = lfsr_step(lfsr);
  assign lane_val = DW'($signed(lfsr_nx[63 -: INPUT_WIDTH]));
  assign clr      = (st == S_IDLE) && start && !abort;
  assign cap      = (st == S_CAPTURE) && !abort;
  // Abort while in DONE swallows the completion pulse
  assign done     = done_q && !(abort && st == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      lane       <= '0;
      scnt       <= '0;
      lfsr       <= 64'h1;
      n_lat      <= '0;
      vec_data   <= '0;
      vec_valid  <= 1'b0;
      busy       <= 1'b0;
      done_q     <= 1'b0;
      sample_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && (st inside {S_GEN, S_SETTLE, S_CAPTURE})) begin
        st        <= S_IDLE;
        vec_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (st)
          S_IDLE: if (start && !abort) begin
            sample_cnt <= '0;
            n_lat      <= num_samples;
            lfsr       <= (seed == '0) ? 64'h1 : seed;
            lane       <= '0;
            if (num_samples == '0) done_q <= 1'b1;
            else begin
              st   <= S_GEN;
              busy <= 1'b1;
            end
          end
          S_GEN: begin
            lfsr           <= lfsr_nx;
            vec_data[lane] <= lane_val;
            if (lane == 4'(LANE_IN_14_1)) begin
              lane      <= '0;
              scnt      <= '0;
              vec_valid <= 1'b1;
              st        <= S_SETTLE;
            end else lane <= lane + 4'd1;
          end
          S_SETTLE: begin
            if (scnt == SCW'(SETTLE-1)) st <= S_CAPTURE;
            else scnt <= scnt + SCW'(1);
          end
          S_CAPTURE: begin
            if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
            vec_valid <= 1'b0;
            if (sample_cnt + CNT_W'(1) == n_lat) begin
              st     <= S_DONE;
              busy   <= 1'b0;
              done_q <= 1'b1;
            end else st <= S_GEN;
          end
          S_DONE:  st <= S_IDLE;
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  arf_err_acc #(.DW(DW), .ER_THRESH1(ER_THRESH1), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_acc_27 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(cap),
    .approx(out_27_var), .exact(out_27_acc),
    .er0_cnt(er0_cnt_27), .er1_cnt(er1_cnt_27), .err_sum(err_sum_27), .abs_max(abs_max_27)
  );

  arf_err_acc #(.DW(DW), .ER_THRESH1(ER_THRESH1), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_acc_28 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(cap),
    .approx(out_28_var), .exact(out_28_acc),
    .er0_cnt(er0_cnt_28), .er1_cnt(er1_cnt_28), .err_sum(err_sum_28), .abs_max(abs_max_28)
  );
endmodule

// File: tb/tb_arf_err_sweep_ctrl.sv
// Scoreboarded bench: stub datapaths, sweep-level reference model, done-triggered monitor.
module tb_arf_err_sweep_ctrl;
  localparam int SET = 4;
  localparam longint MASK48 = (longint'(1) << 48) - 1;

  logic              clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [31:0]       num = 0;
  logic [63:0]       seed_in = 0;
  logic [9:0][31:0]  vec_data;
  logic              vec_valid, busy, done;
  logic [31:0]       a27, e27, a28, e28;
  logic [31:0]       sample_cnt, er0_27, er0_28, er1_27, er1_28;
  logic [47:0]       sum_27, sum_28;
  logic [32:0]       max_27, max_28;

  int          mode = 0;
  logic [31:0] ca27 = 0, ce27 = 0, ca28 = 0, ce28 = 0;
  int          total = 0, bad = 0;
  longint      cyc = 0;

  typedef struct {
    longint n, er0a, er0b, er1a, er1b, suma, sumb, maxa, maxb, due;
  } exp_t;
  exp_t q[$];

  arf_err_sweep_ctrl #(.SETTLE(SET)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_samples(num), .seed(seed_in),
    .vec_data(vec_data), .vec_valid(vec_valid),
    .out_27_var(a27), .out_27_acc(e27), .out_28_var(a28), .out_28_acc(e28),
    .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .er0_cnt_27(er0_27), .er0_cnt_28(er0_28), .er1_cnt_27(er1_27), .er1_cnt_28(er1_28),
    .err_sum_27(sum_27), .err_sum_28(sum_28), .abs_max_27(max_27), .abs_max_28(max_28)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in datapaths: {approx, exact} as arbitrary functions of the lanes
  function automatic logic [63:0] dp27(input logic [9:0][31:0] v);
    logic [31:0] e;
    e = v[0] + v[1];
    return {e ^ (v[2] & 32'h0000_0F0F), e};
  endfunction
  function automatic logic [63:0] dp28(input logic [9:0][31:0] v);
    logic [31:0] e;
    logic signed [31:0] t;
    e = v[3] - v[4];
    t = $signed(v[6]) >>> 20;
    return {(v[5][0] ? e : e + t), e};
  endfunction

  always_comb begin
    a27 = ca27; e27 = ce27; a28 = ca28; e28 = ce28;
    if (mode != 0) begin
      {a27, e27} = dp27(vec_data);
      {a28, e28} = dp28(vec_data);
    end
  end

  function automatic exp_t model(input logic [63:0] sd, input int n, input int md,
                                 input logic [31:0] xa27, xe27, xa28, xe28);
    exp_t r;
    logic [63:0] s, taps;
    logic [9:0][31:0] v;
    logic [31:0] ap[2], ex[2];
    longint e0[2], e1[2], sm[2], mx[2], err, mag;
    taps = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
    v = '0;
    for (int o = 0; o < 2; o++) begin e0[o] = 0; e1[o] = 0; sm[o] = 0; mx[o] = 0; end
    s = (sd == 0) ? 64'd1 : sd;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 10; k++) begin
        s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
        v[k] = {{16{s[63]}}, s[63:48]};
      end
      if (md == 0) begin ap[0] = xa27; ex[0] = xe27; ap[1] = xa28; ex[1] = xe28; end
      else begin {ap[0], ex[0]} = dp27(v); {ap[1], ex[1]} = dp28(v); end
      for (int o = 0; o < 2; o++) begin
        err = longint'($signed(ap[o])) - longint'($signed(ex[o]));
        mag = (err < 0) ? -err : err;
        if (err != 0) e0[o]++;
        if ((ap[o] >> 8) != (ex[o] >> 8)) e1[o]++;
        sm[o] += err;
        if (mag > mx[o]) mx[o] = mag;
      end
    end
    r.n = n; r.er0a = e0[0]; r.er0b = e0[1]; r.er1a = e1[0]; r.er1b = e1[1];
    r.suma = sm[0] & MASK48; r.sumb = sm[1] & MASK48; r.maxa = mx[0]; r.maxb = mx[1];
    r.due = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding sweep
  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n && done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done got=1 want=0 at cyc=%0d", cyc);
      end else begin
        x = q.pop_front();
        chk("done_latency", cyc, x.due);
        chk("sample_cnt", sample_cnt, x.n);
        chk("er0_27", er0_27, x.er0a);
        chk("er0_28", er0_28, x.er0b);
        chk("er1_27", er1_27, x.er1a);
        chk("er1_28", er1_28, x.er1b);
        chk("sum_27", sum_27, x.suma);
        chk("sum_28", sum_28, x.sumb);
        chk("max_27", max_27, x.maxa);
        chk("max_28", max_28, x.maxb);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic run(input logic [63:0] sd, input int n, input bit push);
    exp_t x;
    @(posedge clk); #1;
    start = 1; seed_in = sd; num = n;
    if (push) begin
      x = model(sd, n, mode, ca27, ce27, ca28, ce28);
      x.due = cyc + longint'(n * (11 + SET)) + 1;
      q.push_back(x);
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_q(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout pending=%0d want=0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic set_const(input logic [31:0] a, input logic [31:0] e);
    mode = 0; ca27 = a; ce27 = e; ca28 = a; ce28 = e;
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_vec_data", (vec_data == '0), 1);
    rst_n = 1;

    set_const(32'h10, 32'h10);        run(64'h1234_5678_9ABC_DEF0, 5, 1); wait_q(200);
    set_const(32'h11, 32'h10);        run(64'h5, 7, 1); wait_q(200);
    set_const(32'h110, 32'h10);       run(64'h9, 4, 1); wait_q(200);
    set_const(32'h0, 32'h7FFF_FFFF);  run(64'h0, 3, 1); wait_q(200);
    chk("neg_sum_direct", sum_27, longint'(-64'sd6442450941) & MASK48);
    chk("neg_max_direct", max_28, 64'h7FFF_FFFF);

    // Zero-sample sweep: done after one cycle, busy never rises
    run(64'h77, 0, 1);
    for (int i = 0; i < 4; i++) begin @(negedge clk); chk("busy_n0", busy, 0); end
    wait_q(50);

    // Randomized sweeps through the lane-derived datapath stub
    mode = 1;
    run(64'h0, 2, 1); wait_q(200);
    for (int t = 0; t < 8; t++) begin
      run({$urandom, $urandom}, $urandom_range(1, 6), 1);
      wait_q(200);
    end
    for (int t = 0; t < 3; t++) begin
      set_const($urandom, $urandom);
      ca28 = $urandom; ce28 = ca28 ^ (32'h1 << $urandom_range(0, 31));
      run({$urandom, $urandom}, $urandom_range(1, 5), 1);
      wait_q(200);
    end

    // Second start during a sweep must be ignored
    mode = 1;
    run(64'hCAFE, 3, 1);
    repeat (20) @(posedge clk); #1;
    start = 1; num = 9; seed_in = 64'h99;
    @(posedge clk); #1; start = 0;
    wait_q(200);

    // Abort in SETTLE of the second sample
    set_const(32'h11, 32'h10);
    run(64'h3, 3, 0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (vec_valid && sample_cnt == 1) hit = 1;
    end
    chk("abort_reach_settle", hit, 1);
    abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_vec_valid", vec_valid, 0);
    chk("abort_sample_cnt", sample_cnt, 1);
    chk("abort_er0_kept", er0_27, 1);
    repeat (60) @(posedge clk);

    // Asynchronous reset in the middle of GEN
    mode = 1;
    run(64'hBEEF, 2, 0);
    repeat (3) @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_vec_data", (vec_data == '0), 1);
    chk("arst_sample_cnt", sample_cnt, 0);
    chk("arst_er0", er0_27, 0);
    chk("arst_sum", sum_27, 0);
    chk("arst_max", max_27, 0);
    @(negedge clk); rst_n = 1;

    mode = 1;
    run({$urandom, $urandom}, 3, 1); wait_q(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
